if_id_stage: RTL

- IF/ID pipeline register between Instruction_Fetch_FP and decode.
- Latches the fetched instruction and pc, and detects load-use hazards against the ID/EX stage.
- Generates the multi-cycle `halt` for FP sqrt.
- Drives `hazard_load_indicator` and `halt` back into fetch, and a bubble request to ID/EX.

---
 rtl/if_id_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register between instruction fetch and decode. It latches
// the fetched instruction and its pc, detects load-use hazards against the
// load currently in ID/EX, and sequences the multi-cycle halt that an FP
// sqrt needs.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       synchronous, active-high
//   instruction_in[31:0]        instruction from fetch
//   pc_in[31:0]                 pc of instruction_in
//   branched_address_indicator  branch taken: flush IF/ID
//   idex_mem_read               ID/EX holds a load
//   idex_rd[4:0]                destination register of that load
//   instruction_out[31:0]       instruction to decode (32'h0 = NOP)
//   pc_out[31:0]                pc to decode
//   valid_out                   instruction_out is a live instruction
//   hazard_load_indicator       load-use stall request to fetch
//   halt                        multi-cycle (sqrt) stall request to fetch
//   id_bubble                   ID/EX must load a NOP this cycle
//   fsm_state[1:0]              debug view of the halt sequencer state
//
// Flow control: there is no ready input. Fetch treats
// (hazard_load_indicator | halt) as "not ready": while either is high the
// IF/ID registers hold and fetch must present the same instruction again.
// A flush (branched_address_indicator) overrides both stalls in the same
// cycle so fetch can redirect immediately.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [5:0] FP_OPCODE    = 6'h11,
  parameter logic [5:0] SQRT_FUNCT   = 6'h04,
  parameter int unsigned SQRT_LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        branched_address_indicator,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        hazard_load_indicator,
  output logic        halt,
  output logic        id_bubble,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The detect cycle in IDLE is the first halt cycle, so BUSY must run
  // SQRT_LATENCY-1 cycles: counting SQRT_LATENCY-2 down to 0 inclusive.
  localparam logic [7:0] CNT_LOAD = 8'(SQRT_LATENCY - 2);

  state_t     state;
  logic [7:0] counter;

  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flush;
  logic       raw_hazard;
  logic       sqrt_hit;
  logic       hazard_int;
  logic       halt_int;
  logic       stall;

  assign rs     = instruction_out[25:21];
  assign rt     = instruction_out[20:16];
  assign opcode = instruction_out[31:26];
  assign funct  = instruction_out[5:0];
  assign flush  = branched_address_indicator;

  // In DONE the sqrt has to leave IF/ID this edge, so a load-use match is
  // ignored there; otherwise the sqrt would be re-detected and halt again.
  assign raw_hazard = valid_out & idex_mem_read & (idex_rd != 5'd0) &
                      ((idex_rd == rs) | (idex_rd == rt)) & (state != DONE);

  // A pending load-use hazard takes priority over starting a sqrt halt.
  assign sqrt_hit = valid_out & (opcode == FP_OPCODE) &
                    (funct == SQRT_FUNCT) & ~raw_hazard;

  assign hazard_int = raw_hazard & ~flush;
  assign halt_int   = (((state == IDLE) & sqrt_hit) | (state == BUSY)) & ~flush;
  assign stall      = hazard_int | halt_int;

  // While reset is asserted all control outputs read 0, including the
  // bubble that an empty IF/ID would otherwise request.
  assign hazard_load_indicator = hazard_int & ~reset;
  assign halt                  = halt_int & ~reset;
  assign id_bubble             = ~reset & (hazard_int | halt_int | ~valid_out);

  assign fsm_state = state;

  // IF/ID registers: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_out <= 32'h0;
      pc_out          <= 32'h0;
      valid_out       <= 1'b0;
    end else if (flush) begin
      instruction_out <= 32'h0;
      valid_out       <= 1'b0;
    end else if (!stall) begin
      instruction_out <= instruction_in;
      pc_out          <= pc_in;
      valid_out       <= 1'b1;
    end
  end

  // Halt sequencer. A flush in any state abandons the pending sqrt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 8'd0;
    end else if (flush) begin
      state   <= IDLE;
      counter <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sqrt_hit) begin
            state   <= BUSY;
            counter <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (counter == 8'd0) begin
            state <= DONE;
          end else begin
            counter <= counter - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          counter <= 8'd0;
        end
      endcase
    end
  end

endmodule
